// File: rtl/quote_pkg.sv
// quote_pkg: shared definitions for the quote engine.
//   Q32.32 constants and saturation limits, fill side encoding, stock id type.
package quote_pkg;

   localparam int FRAC_BITS = 32;
   localparam int FP_W      = 64;
   localparam int SKEW_W    = 48;

   localparam logic [FP_W-1:0]          UQ_MAX   = '1;
   localparam logic signed [SKEW_W-1:0] SKEW_MAX = {1'b0, {(SKEW_W-1){1'b1}}};
   localparam logic signed [SKEW_W-1:0] SKEW_MIN = {1'b1, {(SKEW_W-1){1'b0}}};

   typedef enum logic {
      FILL_BUY  = 1'b0,
      FILL_SELL = 1'b1
   } fill_side_e;

   localparam int NUM_STOCKS_DEF = 4;
   typedef logic [$clog2(NUM_STOCKS_DEF)-1:0] stock_id_t;

endpackage

// File: rtl/quote_engine_fp_mul_sat.sv
// fp_mul_sat: registered Q32.32 multiply, latency 1.
//   a     unsigned Q32.32 operand
//   b     B_W-bit operand, unsigned or signed (B_SIGNED)
//   y     (a*b) >>> SHIFT, saturated to OUT_W bits (unsigned or signed)
// The arithmetic right shift floors toward -inf for signed products.
module fp_mul_sat
   import quote_pkg::*;
#(
   parameter int A_W      = FP_W,
   parameter int B_W      = FP_W,
   parameter bit B_SIGNED = 1'b0,
   parameter int SHIFT    = FRAC_BITS,
   parameter int OUT_W    = FP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   output logic [OUT_W-1:0] y
);

   localparam int PW = A_W + B_W + 2;

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic [OUT_W-1:0]     sat;

   assign a_ext   = $signed({{(PW-A_W){1'b0}}, a});
   assign b_ext   = B_SIGNED ? $signed({{(PW-B_W){b[B_W-1]}}, b})
                             : $signed({{(PW-B_W){1'b0}}, b});
   assign prod    = a_ext * b_ext;
   assign shifted = prod >>> SHIFT;

   always_comb begin
      sat = shifted[OUT_W-1:0];
      if (B_SIGNED) begin
         // in range only when all bits above the result sign match it
         if (!((&shifted[PW-1:OUT_W-1]) || !(|shifted[PW-1:OUT_W-1])))
            sat = shifted[PW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         if (|shifted[PW-1:OUT_W])
            sat = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) y <= '0;
      else        y <= sat;
   end

endmodule

// File: rtl/quote_engine.sv
// quote_engine: per-stock inventory-skewed bid/ask quote generator.
//   Market update (i_data_valid, i_stock_id, i_curr_price, i_volatility,
//   i_buffer_full) -> quote 4 edges later (o_quote_valid pulse, o_stock_id,
//   o_bid_price, o_ask_price, o_bid_enable, o_ask_enable, o_inventory).
//   Fill port (i_fill_*) updates a saturating signed inventory per stock.
//   Quasi-static knobs: i_gamma (used by S2), i_half_spread and i_inv_limit
//   (used by the output stage).
// Pipeline: S1 capture+inventory read, S2 p1=gamma*var, S3 skew=floor(p1*q),
//   S4 r=s-skew, output stage clamps r -/+ half_spread.
module quote_engine
   import quote_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_STOCKS   = 4,
   parameter int FP_WORD_SIZE = 64,
   parameter int INV_WIDTH    = 32
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_data_valid,
   input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
   input  logic [DATA_WIDTH-1:0]         i_curr_price,
   input  logic [FP_WORD_SIZE-1:0]       i_volatility,
   input  logic                          i_buffer_full,
   input  logic [FP_WORD_SIZE-1:0]       i_gamma,
   input  logic [DATA_WIDTH-1:0]         i_half_spread,
   input  logic [INV_WIDTH-1:0]          i_inv_limit,
   input  logic                          i_fill_valid,
   input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock_id,
   input  logic                          i_fill_side,
   input  logic [15:0]                   i_fill_qty,
   output logic                          o_quote_valid,
   output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
   output logic [DATA_WIDTH-1:0]         o_bid_price,
   output logic [DATA_WIDTH-1:0]         o_ask_price,
   output logic                          o_bid_enable,
   output logic                          o_ask_enable,
   output logic [INV_WIDTH-1:0]          o_inventory
);

   localparam int ID_W = $clog2(NUM_STOCKS);
   localparam int R_W  = SKEW_W + 1;
   localparam int X_W  = R_W + 2;

   // ---------------- inventory file ----------------
   logic signed [INV_WIDTH-1:0] inv [NUM_STOCKS];
   logic signed [INV_WIDTH:0]   fill_cur;
   logic signed [INV_WIDTH:0]   fill_delta;
   logic signed [INV_WIDTH:0]   fill_sum;
   logic signed [INV_WIDTH-1:0] fill_next;

   always_comb begin
      fill_cur   = {inv[i_fill_stock_id][INV_WIDTH-1], inv[i_fill_stock_id]};
      fill_delta = $signed({{(INV_WIDTH+1-16){1'b0}}, i_fill_qty});
      if (fill_side_e'(i_fill_side) == FILL_SELL) fill_sum = fill_cur - fill_delta;
      else                                        fill_sum = fill_cur + fill_delta;
      fill_next = fill_sum[INV_WIDTH-1:0];
      if (fill_sum[INV_WIDTH] != fill_sum[INV_WIDTH-1])
         fill_next = fill_sum[INV_WIDTH] ? {1'b1, {(INV_WIDTH-1){1'b0}}}
                                         : {1'b0, {(INV_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_STOCKS; i++) inv[i] <= '0;
      end else if (i_fill_valid) begin
         inv[i_fill_stock_id] <= fill_next;
      end
   end

   // ---------------- pipeline ----------------
   logic                        s1_valid, s2_valid, s3_valid, s4_valid;
   logic [ID_W-1:0]             s1_id, s2_id, s3_id, s4_id;
   logic [DATA_WIDTH-1:0]       s1_price, s2_price, s3_price;
   logic [FP_WORD_SIZE-1:0]     s1_vol;
   logic signed [INV_WIDTH-1:0] s1_q, s2_q, s3_q, s4_q;
   logic [FP_WORD_SIZE-1:0]     p1;
   logic [SKEW_W-1:0]           skew;
   logic signed [R_W-1:0]       s4_r;

   // S1 samples inventory before this edge's fill, so a same-cycle fill
   // only affects later updates.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_price <= '0;
         s1_vol   <= '0;
         s1_q     <= '0;
      end else begin
         s1_valid <= i_data_valid && i_buffer_full;
         if (i_data_valid && i_buffer_full) begin
            s1_id    <= i_stock_id;
            s1_price <= i_curr_price;
            s1_vol   <= i_volatility;
            s1_q     <= inv[i_stock_id];
         end
      end
   end

   fp_mul_sat #(
      .A_W(FP_WORD_SIZE), .B_W(FP_WORD_SIZE), .B_SIGNED(1'b0),
      .SHIFT(FRAC_BITS), .OUT_W(FP_WORD_SIZE)
   ) u_mul_var (
      .clk(i_clk), .rst_n(i_reset_n), .a(i_gamma), .b(s1_vol), .y(p1)
   );

   fp_mul_sat #(
      .A_W(FP_WORD_SIZE), .B_W(INV_WIDTH), .B_SIGNED(1'b1),
      .SHIFT(FRAC_BITS), .OUT_W(SKEW_W)
   ) u_mul_inv (
      .clk(i_clk), .rst_n(i_reset_n), .a(p1), .b(s2_q), .y(skew)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s2_valid <= 1'b0;
         s2_id    <= '0;
         s2_price <= '0;
         s2_q     <= '0;
         s3_valid <= 1'b0;
         s3_id    <= '0;
         s3_price <= '0;
         s3_q     <= '0;
         s4_valid <= 1'b0;
         s4_id    <= '0;
         s4_q     <= '0;
         s4_r     <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
         s2_price <= s1_price;
         s2_q     <= s1_q;
         s3_valid <= s2_valid;
         s3_id    <= s2_id;
         s3_price <= s2_price;
         s3_q     <= s2_q;
         s4_valid <= s3_valid;
         s4_id    <= s3_id;
         s4_q     <= s3_q;
         s4_r     <= $signed({{(R_W-DATA_WIDTH){1'b0}}, s3_price})
                   - $signed({skew[SKEW_W-1], skew});
      end
   end

   // ---------------- output stage ----------------
   function automatic logic [DATA_WIDTH-1:0] clamp_price(input logic signed [X_W-1:0] x);
      if (x[X_W-1])                  return '0;
      else if (|x[X_W-1:DATA_WIDTH]) return '1;
      else                           return x[DATA_WIDTH-1:0];
   endfunction

   logic signed [X_W-1:0]       r_ext;
   logic signed [X_W-1:0]       hs_ext;
   logic signed [INV_WIDTH:0]   q_ext;
   logic signed [INV_WIDTH:0]   lim_ext;

   assign r_ext   = {{(X_W-R_W){s4_r[R_W-1]}}, s4_r};
   assign hs_ext  = $signed({{(X_W-DATA_WIDTH){1'b0}}, i_half_spread});
   assign q_ext   = {s4_q[INV_WIDTH-1], s4_q};
   assign lim_ext = $signed({i_inv_limit[INV_WIDTH-1], i_inv_limit});

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_quote_valid <= 1'b0;
         o_stock_id    <= '0;
         o_bid_price   <= '0;
         o_ask_price   <= '0;
         o_bid_enable  <= 1'b0;
         o_ask_enable  <= 1'b0;
         o_inventory   <= '0;
      end else begin
         o_quote_valid <= s4_valid;
         if (s4_valid) begin
            o_stock_id   <= s4_id;
            o_bid_price  <= clamp_price(r_ext - hs_ext);
            o_ask_price  <= clamp_price(r_ext + hs_ext);
            o_bid_enable <= q_ext < lim_ext;
            o_ask_enable <= q_ext > -lim_ext;
            o_inventory  <= s4_q;
         end
      end
   end

endmodule

// File: tb/tb_quote_engine.sv
// tb_quote_engine: directed + randomized checks of quote_engine against a
// behavioural quote model (inventory array, wide-integer pricing math).
module tb_quote_engine;
   import quote_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_valid, buffer_full, fill_valid, fill_side;
   stock_id_t   stock_id, fill_stock_id;
   logic [31:0] curr_price, half_spread, inv_limit;
   logic [63:0] volatility, gamma;
   logic [15:0] fill_qty;
   logic        quote_valid, bid_enable, ask_enable;
   stock_id_t   out_id;
   logic [31:0] bid_price, ask_price, inventory;

   always #5 clk = ~clk;

   quote_engine dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_data_valid(data_valid), .i_stock_id(stock_id),
      .i_curr_price(curr_price), .i_volatility(volatility),
      .i_buffer_full(buffer_full), .i_gamma(gamma),
      .i_half_spread(half_spread), .i_inv_limit(inv_limit),
      .i_fill_valid(fill_valid), .i_fill_stock_id(fill_stock_id),
      .i_fill_side(fill_side), .i_fill_qty(fill_qty),
      .o_quote_valid(quote_valid), .o_stock_id(out_id),
      .o_bid_price(bid_price), .o_ask_price(ask_price),
      .o_bid_enable(bid_enable), .o_ask_enable(ask_enable),
      .o_inventory(inventory)
   );

   typedef struct {
      longint      due;
      stock_id_t   id;
      logic [31:0] bid, ask, inv;
      logic        be, ae;
   } quote_t;

   quote_t expq[$];
   quote_t obs_q[$];
   longint minv [4];
   longint cyc = 0;
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic longint clampp(input longint v);
      if (v < 0) return 0;
      if (v > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
      return v;
   endfunction

   // Quote from first principles: r = s - floor(gamma*var*q), clamped prices.
   function automatic quote_t predict(input stock_id_t id, input logic [31:0] s,
                                      input logic [63:0] sig);
      quote_t e;
      logic [127:0] g2;
      logic [63:0]  p1;
      logic signed [127:0] qq, prod, sk, skmax, skmin;
      longint q, skew, r, sl, hs, lim;
      q     = minv[id];
      g2    = {64'd0, gamma} * {64'd0, sig};
      p1    = (g2[127:96] != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : g2[95:32];
      qq    = q;
      prod  = $signed({64'd0, p1}) * qq;
      sk    = prod >>> 32;
      skmax = 128'sh7FFF_FFFF_FFFF;
      skmin = -skmax - 1;
      if (sk > skmax)      skew = 64'sh7FFF_FFFF_FFFF;
      else if (sk < skmin) skew = -64'sh8000_0000_0000;
      else                 skew = sk[63:0];
      sl    = {32'd0, s};
      hs    = {32'd0, half_spread};
      lim   = $signed(inv_limit);
      r     = sl - skew;
      e.due = 0;
      e.id  = id;
      e.bid = 32'(clampp(r - hs));
      e.ask = 32'(clampp(r + hs));
      e.be  = q < lim;
      e.ae  = q > -lim;
      e.inv = q[31:0];
      return e;
   endfunction

   function automatic longint apply_fill(input longint v, input logic side, input logic [15:0] qty);
      longint n;
      n = side ? v - longint'(qty) : v + longint'(qty);
      if (n > 64'sh7FFF_FFFF)  n = 64'sh7FFF_FFFF;
      if (n < -64'sh8000_0000) n = -64'sh8000_0000;
      return n;
   endfunction

   task automatic tick();
      quote_t e;
      bit have = 0;
      if (rst_n && data_valid && buffer_full) begin
         e = predict(stock_id, curr_price, volatility);
         have = 1;
      end
      if (rst_n && fill_valid)
         minv[fill_stock_id] = apply_fill(minv[fill_stock_id], fill_side, fill_qty);
      @(posedge clk);
      cyc++;
      if (have) begin
         e.due = cyc + 4;
         expq.push_back(e);
      end
      #1;
      data_valid = 0;
      fill_valid = 0;
      if (quote_valid === 1'b1) begin
         e.id = out_id; e.bid = bid_price; e.ask = ask_price;
         e.be = bid_enable; e.ae = ask_enable; e.inv = inventory;
         obs_q.push_back(e);
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
         e = expq.pop_front();
         chk("quote_valid", {63'd0, quote_valid}, 64'd1);
         chk("stock_id", {62'd0, out_id}, {62'd0, e.id});
         chk("bid_price", {32'd0, bid_price}, {32'd0, e.bid});
         chk("ask_price", {32'd0, ask_price}, {32'd0, e.ask});
         chk("bid_enable", {63'd0, bid_enable}, {63'd0, e.be});
         chk("ask_enable", {63'd0, ask_enable}, {63'd0, e.ae});
         chk("inventory", {32'd0, inventory}, {32'd0, e.inv});
      end else begin
         chk("no_quote", {63'd0, quote_valid}, 64'd0);
      end
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
   endtask

   task automatic upd(input stock_id_t id, input logic [31:0] s, input logic [63:0] sig,
                      input logic full);
      data_valid = 1; stock_id = id; curr_price = s; volatility = sig; buffer_full = full;
   endtask

   task automatic fill(input stock_id_t id, input logic side, input logic [15:0] qty);
      fill_valid = 1; fill_stock_id = id; fill_side = side; fill_qty = qty;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", {63'd0, quote_valid}, 64'd0);
      chk("rst_bid", {32'd0, bid_price}, 64'd0);
      chk("rst_ask", {32'd0, ask_price}, 64'd0);
      chk("rst_en", {62'd0, bid_enable, ask_enable}, 64'd0);
      chk("rst_inv", {32'd0, inventory}, 64'd0);
      chk("rst_id", {62'd0, out_id}, 64'd0);
   endtask

   localparam logic [63:0] VAR4 = 64'h4_0000_0000;
   localparam logic [63:0] G_HALF = 64'h0_8000_0000;

   initial begin
      int n;
      rst_n = 1; data_valid = 0; buffer_full = 0; fill_valid = 0; fill_side = 0;
      stock_id = '0; fill_stock_id = '0; curr_price = 0; volatility = 0;
      fill_qty = 0; gamma = G_HALF; half_spread = 5; inv_limit = 1000;
      for (int i = 0; i < 4; i++) minv[i] = 0;
      #2 rst_n = 0;
      @(posedge clk); #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1;

      // basic quote: q=+10, var=4.0, gamma=0.5 -> skew 20
      fill(0, FILL_BUY, 10); tick();
      upd(0, 1000, VAR4, 1); tick();
      obs_q.delete(); drain(6);
      chk("basic_count", obs_q.size(), 1);
      if (obs_q.size() == 1) begin
         chk("basic_bid", {32'd0, obs_q[0].bid}, 975);
         chk("basic_ask", {32'd0, obs_q[0].ask}, 985);
         chk("basic_en", {62'd0, obs_q[0].be, obs_q[0].ae}, 3);
      end

      // warm-up gating
      obs_q.delete();
      upd(1, 500, VAR4, 0); tick(); drain(6);
      chk("warmup_drop", obs_q.size(), 0);
      upd(1, 500, VAR4, 1); tick(); drain(6);
      chk("warmup_next", obs_q.size(), 1);

      // fill/update collision on stock 2
      obs_q.delete();
      fill(2, FILL_BUY, 100); upd(2, 2000, VAR4, 1); tick();
      upd(2, 2000, VAR4, 1); tick(); drain(6);
      chk("coll_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("coll_inv0", {32'd0, obs_q[0].inv}, 0);
         chk("coll_bid0", {32'd0, obs_q[0].bid}, 1995);
         chk("coll_inv1", {32'd0, obs_q[1].inv}, 100);
         chk("coll_bid1", {32'd0, obs_q[1].bid}, 1795);
      end

      // saturation low: s=10, skew=+50
      obs_q.delete();
      fill(1, FILL_BUY, 25); tick();
      upd(1, 10, VAR4, 1); tick(); drain(6);
      // saturation high: s=2^32-3, q=-10
      fill(3, FILL_SELL, 10); tick();
      upd(3, 32'hFFFF_FFFD, VAR4, 1); tick(); drain(6);
      chk("sat_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("sat_bid_low", {32'd0, obs_q[0].bid}, 0);
         chk("sat_ask_low", {32'd0, obs_q[0].ask}, 0);
         chk("sat_ask_high", {32'd0, obs_q[1].ask}, 64'hFFFF_FFFF);
      end

      // inventory limit at +100 / -100
      obs_q.delete();
      inv_limit = 100;
      upd(2, 3000, VAR4, 1); tick();
      fill(3, FILL_SELL, 90); tick();
      upd(3, 3000, VAR4, 1); tick(); drain(6);
      chk("lim_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("lim_pos_en", {62'd0, obs_q[0].be, obs_q[0].ae}, 1);
         chk("lim_neg_en", {62'd0, obs_q[1].be, obs_q[1].ae}, 2);
      end

      // back-to-back throughput
      obs_q.delete();
      for (int i = 0; i < 4; i++) begin
         upd(stock_id_t'(i), 32'(5000 + i), VAR4, 1); tick();
      end
      drain(6);
      chk("tput_count", obs_q.size(), 4);
      if (obs_q.size() == 4)
         for (int i = 0; i < 4; i++) chk("tput_id", {62'd0, obs_q[i].id}, 64'(i));

      // randomized mix
      gamma = {30'd0, 2'($urandom_range(0, 3)), $urandom};
      inv_limit = 32'($urandom_range(50, 400));
      half_spread = 32'($urandom_range(0, 1000));
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 9) == 0)
               upd(stock_id_t'($urandom_range(0, 3)), $urandom, {$urandom, $urandom},
                   ($urandom_range(0, 6) != 0));
            else
               upd(stock_id_t'($urandom_range(0, 3)), $urandom,
                   {28'd0, 4'($urandom_range(0, 15)), $urandom},
                   ($urandom_range(0, 6) != 0));
         end
         if ($urandom_range(0, 9) < 4)
            fill(stock_id_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 300)));
         tick();
      end
      drain(6);

      // reset in the middle of a burst
      gamma = G_HALF; half_spread = 5; inv_limit = 1000;
      fill(0, FILL_BUY, 40); tick();
      obs_q.delete();
      upd(0, 7000, VAR4, 1); tick();
      upd(1, 7001, VAR4, 1); tick();
      rst_n = 0;
      expq.delete();
      for (int i = 0; i < 4; i++) minv[i] = 0;
      #1;
      chk_reset_outputs();
      upd(2, 7002, VAR4, 1); tick();
      drain(2);
      rst_n = 1;
      drain(8);
      chk("rst_no_quotes", obs_q.size(), 0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         upd(stock_id_t'(i), 8000, VAR4, 1); tick();
      end
      drain(6);
      chk("post_rst_count", obs_q.size(), 4);
      foreach (obs_q[i]) begin
         chk("post_rst_inv", {32'd0, obs_q[i].inv}, 0);
         chk("post_rst_bid", {32'd0, obs_q[i].bid}, 7995);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
